// File: rtl/sarray_storec.sv
// Drain stage for the systolic array: buffers bottom-port result rows in a
// small FIFO and issues one AW store per row at base + cnt * row stride.
module sarray_storec #(
  parameter int ADDR_WIDTH         = 64,
  parameter int SARRAY_STORE_WIDTH = 256,
  parameter int TMMA_CNT_WIDTH     = 6,
  parameter int ROW_STRIDE_SHIFT   = 8,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          storec_cmd_valid_i,
  output logic                          storec_cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]         storec_cmd_addr_i,
  input  logic                          bot_valid_i,
  input  logic [TMMA_CNT_WIDTH-1:0]     bot_cnt_i,
  input  logic [SARRAY_STORE_WIDTH-1:0] bot_data_i,
  output logic                          bot_stall_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [ADDR_WIDTH-1:0]         aw_addr_o,
  output logic [SARRAY_STORE_WIDTH-1:0] aw_data_o,
  output logic                          storec_done_o,
  output logic                          err_drop_o
);

  localparam int ROWS   = 2 ** TMMA_CNT_WIDTH;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int SENT_W = TMMA_CNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state;
  logic [TMMA_CNT_WIDTH-1:0]       mem_cnt  [FIFO_DEPTH];
  logic [SARRAY_STORE_WIDTH-1:0]   mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]                rd_ptr, wr_ptr;
  logic [OCC_W-1:0]                occ;
  logic [SENT_W-1:0]               sent;
  logic [ADDR_WIDTH-1:0]           base;
  logic                            err_drop;
  logic                            fifo_full, fifo_empty, push, pop;

  always_comb begin
    fifo_full          = (occ == OCC_W'(FIFO_DEPTH));
    fifo_empty         = (occ == '0);
    aw_valid_o         = (state == RUN) && !fifo_empty;
    pop                = aw_valid_o && aw_ready_i;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push               = bot_valid_i && (state == RUN) && (!fifo_full || pop);
    storec_cmd_ready_o = (state == IDLE);
    storec_done_o      = (state == DONE);
    bot_stall_o        = (occ >= OCC_W'(FIFO_DEPTH - 2));
    err_drop_o         = err_drop;
    aw_addr_o          = '0;
    aw_data_o          = '0;
    if (aw_valid_o) begin
      aw_addr_o = base + (ADDR_WIDTH'(mem_cnt[rd_ptr]) << ROW_STRIDE_SHIFT);
      aw_data_o = mem_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cnt[wr_ptr]  <= bot_cnt_i;
      mem_data[wr_ptr] <= bot_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      sent     <= '0;
      base     <= '0;
      err_drop <= 1'b0;
    end else begin
      if (bot_valid_i && !push) err_drop <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
      case (state)
        IDLE: if (storec_cmd_valid_i) begin
          base  <= storec_cmd_addr_i;
          sent  <= '0;
          state <= RUN;
        end
        RUN: if (pop) begin
          sent <= sent + SENT_W'(1);
          if (sent == SENT_W'(ROWS - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
